// File: rtl/resp_arb.sv
// -----------------------------------------------------------------------------
// resp_arb
//
// Shares the single BLE UART transmit path between four status sources.
// One-cycle request pulses are latched into a pending mask and served
// round-robin. For each grant the response byte is registered and trmt_o is
// pulsed for one cycle. The channel is then held until tx_done_i comes back,
// after which ack_o pulses on the bit of the requester whose byte went out.
//
// Optional feature (compile-time macro RESP_HB_EN):
//   Adds a free-running heartbeat counter. Each time the interval elapses it
//   raises an internal heartbeat request. That request is served only when no
//   requester is pending. It sends 8'h3C, leaves the round-robin pointer
//   alone and produces no ack. With the macro undefined no heartbeat logic is
//   built, and HB_PERIOD and FAST_SIM have no effect.
//
// Ports:
//   clk        in   system clock
//   rst_n      in   asynchronous active-low reset
//   req_i      in   [3:0] request pulses, one bit per requester
//   tx_done_i  in   UART wrapper: byte transmission complete
//   clr_ovf_i  in   clears all overflow flags
//   trmt_o     out  one-cycle pulse that starts a UART transmission
//   resp_o     out  [7:0] byte to transmit, held until the next grant
//   ack_o      out  [3:0] one-cycle pulse for the requester whose byte finished
//   busy_o     out  high while sending or waiting for tx_done_i
//   ovf_o      out  [3:0] sticky: request arrived while already pending
// -----------------------------------------------------------------------------
module resp_arb #(
    parameter logic [7:0]  RESP0     = 8'hA5,
    parameter logic [7:0]  RESP1     = 8'h5A,
    parameter logic [7:0]  RESP2     = 8'hC3,
    parameter logic [7:0]  RESP3     = 8'hE1,
    parameter logic [23:0] HB_PERIOD = 24'd5_000_000,
    parameter bit          FAST_SIM  = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req_i,
    input  logic       tx_done_i,
    input  logic       clr_ovf_i,
    output logic       trmt_o,
    output logic [7:0] resp_o,
    output logic [3:0] ack_o,
    output logic       busy_o,
    output logic [3:0] ovf_o
);

    typedef enum logic [1:0] {S_IDLE, S_SEND, S_WAIT} state_t;

    state_t     state_q, state_d;
    logic [3:0] pend_q, pend_d;
    logic [3:0] ovf_q, ovf_d;
    logic [1:0] ptr_q, ptr_d;
    logic [1:0] gidx_q, gidx_d;
    logic [7:0] resp_q, resp_d;
    logic       done_q, done_d;   // first idle cycle after a completed byte

    logic [1:0] win_idx;
    logic       grant;
    logic       hb_grant;
    logic       hb_req;
    logic       hb_active;
    logic [3:0] grant_mask;

    // Round-robin winner: scan from the highest offset down so the lowest
    // offset from ptr_q is the last assignment and therefore wins.
    always_comb begin
        logic [1:0] idx;
        win_idx = ptr_q;
        for (int k = 3; k >= 0; k--) begin
            idx = ptr_q + 2'(k);
            if (pend_q[idx]) begin
                win_idx = idx;
            end
        end
    end

    // FSM: state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state. The idle cycle that carries the ack is not allowed to
    // grant, so a request still pending at completion starts two cycles later.
    always_comb begin
        state_d  = state_q;
        grant    = 1'b0;
        hb_grant = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!done_q) begin
                    if (|pend_q) begin
                        grant   = 1'b1;
                        state_d = S_SEND;
                    end else if (hb_req) begin
                        hb_grant = 1'b1;
                        state_d  = S_SEND;
                    end
                end
            end
            S_SEND:  state_d = S_WAIT;
            S_WAIT:  if (tx_done_i) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        trmt_o = (state_q == S_SEND);
        busy_o = (state_q == S_SEND) || (state_q == S_WAIT);
        resp_o = resp_q;
        ovf_o  = ovf_q;
        ack_o  = 4'b0000;
        if (done_q && !hb_active) begin
            ack_o = 4'b0001 << gidx_q;
        end
    end

    // Datapath next values
    always_comb begin
        grant_mask = grant ? (4'b0001 << win_idx) : 4'b0000;
        // A request landing on the bit being granted re-arms it without
        // counting as an overflow.
        pend_d = (pend_q & ~grant_mask) | req_i;
        ovf_d  = (clr_ovf_i ? 4'b0000 : ovf_q) | (req_i & pend_q & ~grant_mask);
        ptr_d  = grant ? (win_idx + 2'd1) : ptr_q;
        gidx_d = grant ? win_idx : gidx_q;
        done_d = (state_q == S_WAIT) && tx_done_i;
        resp_d = resp_q;
        if (grant) begin
            case (win_idx)
                2'd0:    resp_d = RESP0;
                2'd1:    resp_d = RESP1;
                2'd2:    resp_d = RESP2;
                default: resp_d = RESP3;
            endcase
        end else if (hb_grant) begin
            resp_d = 8'h3C;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q <= 4'b0000;
            ovf_q  <= 4'b0000;
            ptr_q  <= 2'd0;
            gidx_q <= 2'd0;
            resp_q <= 8'h00;
            done_q <= 1'b0;
        end else begin
            pend_q <= pend_d;
            ovf_q  <= ovf_d;
            ptr_q  <= ptr_d;
            gidx_q <= gidx_d;
            resp_q <= resp_d;
            done_q <= done_d;
        end
    end

`ifdef RESP_HB_EN
    localparam logic [23:0] HB_LIMIT = FAST_SIM ? (HB_PERIOD >> 6) : HB_PERIOD;

    logic [23:0] hb_cnt_q, hb_cnt_d;
    logic        hb_pend_q, hb_pend_d;
    logic        hb_sel_q, hb_sel_d;   // current transfer is a heartbeat
    logic        hb_tick;

    always_comb begin
        hb_tick  = (hb_cnt_q == HB_LIMIT - 24'd1);
        hb_cnt_d = hb_tick ? 24'd0 : hb_cnt_q + 24'd1;
        // A tick while a heartbeat is already waiting simply merges into it.
        hb_pend_d = (hb_pend_q & ~hb_grant) | hb_tick;
        hb_sel_d  = hb_grant ? 1'b1 : (grant ? 1'b0 : hb_sel_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hb_cnt_q  <= 24'd0;
            hb_pend_q <= 1'b0;
            hb_sel_q  <= 1'b0;
        end else begin
            hb_cnt_q  <= hb_cnt_d;
            hb_pend_q <= hb_pend_d;
            hb_sel_q  <= hb_sel_d;
        end
    end

    assign hb_req    = hb_pend_q;
    assign hb_active = hb_sel_q;
`else
    logic unused_hb;
    assign hb_req    = 1'b0;
    assign hb_active = 1'b0;
    assign unused_hb = ^{HB_PERIOD, FAST_SIM, hb_grant};
`endif

endmodule

// File: tb/tb_resp_arb.sv
module tb_resp_arb;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] req;
    logic       tx_done;
    logic       clr_ovf;
    logic       trmt;
    logic [7:0] resp;
    logic [3:0] ack;
    logic       busy;
    logic [3:0] ovf;

    always #5 clk = ~clk;

    resp_arb #(
        .HB_PERIOD (24'd6400),
        .FAST_SIM  (1'b1)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_i     (req),
        .tx_done_i (tx_done),
        .clr_ovf_i (clr_ovf),
        .trmt_o    (trmt),
        .resp_o    (resp),
        .ack_o     (ack),
        .busy_o    (busy),
        .ovf_o     (ovf)
    );

    typedef struct packed {
        logic [7:0] resp;
        logic [3:0] ack;
    } exp_t;

    typedef struct {
        logic [3:0]  req;
        int          delay;
        int          n;
        logic [31:0] bytes;
        logic [15:0] acks;
    } vec_t;

    exp_t       sb[$];
    logic [3:0] cur_ack_exp = 4'b0000;
    int         n_checks = 0;
    int         n_fail   = 0;
    vec_t       vecs[6];

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endfunction

    function automatic void push(logic [7:0] r, logic [3:0] a);
        exp_t e;
        e.resp = r;
        e.ack  = a;
        sb.push_back(e);
    endfunction

    // Scoreboard side: every trmt pulse consumes one expected byte.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && trmt === 1'b1) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_trmt: got resp %0h, expected no transmission", resp);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("resp", resp, e.resp);
                check("busy_at_trmt", busy, 1);
                cur_ack_exp = e.ack;
                $display("tx resp=%h ack_exp=%b", resp, e.ack);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_trmt(int max, output int waited);
        waited = 0;
        while (trmt !== 1'b1 && waited < max) begin
            step();
            waited++;
        end
        if (trmt !== 1'b1) begin
            n_checks++;
            n_fail++;
            $display("FAIL trmt_timeout: got no trmt, expected one within %0d cycles", max);
        end
    endtask

    // Called in the first WAIT cycle; returns in the cycle after tx_done.
    task automatic finish_byte(int delay);
        repeat (delay) step();
        tx_done = 1'b1;
        step();
        tx_done = 1'b0;
        check("ack", ack, cur_ack_exp);
        check("busy_after_done", busy, 0);
    endtask

    task automatic serve(int n, int delay);
        int waited;
        for (int i = 0; i < n; i++) begin
            wait_trmt(300, waited);
            if (i > 0) check("regrant_gap", waited, 2);
            step();
            finish_byte(delay);
        end
    endtask

    // Drive a one-cycle request pulse and check the two-cycle trmt latency.
    task automatic pulse_req_latency(logic [3:0] r);
        req = r;
        step();
        req = 4'b0000;
        check("busy_grant_cycle", busy, 0);
        step();
        check("trmt_latency", trmt, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test, expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{4'b1111, 7,   4, 32'hA55AC3E1, 16'b0001_0010_0100_1000};
        vecs[1] = '{4'b0001, 100, 1, 32'hA5000000, 16'b0001_0000_0000_0000};
        vecs[2] = '{4'b0011, 4,   2, 32'h5AA50000, 16'b0010_0001_0000_0000};
        vecs[3] = '{4'b1100, 2,   2, 32'hC3E10000, 16'b0100_1000_0000_0000};
        vecs[4] = '{4'b0110, 0,   2, 32'h5AC30000, 16'b0010_0100_0000_0000};
        vecs[5] = '{4'b1001, 1,   2, 32'hE1A50000, 16'b1000_0001_0000_0000};

        rst_n   = 1'b0;
        req     = 4'b0000;
        tx_done = 1'b0;
        clr_ovf = 1'b0;
        repeat (3) step();
        check("rst_trmt", trmt, 0);
        check("rst_resp", resp, 8'h00);
        check("rst_ack",  ack, 0);
        check("rst_busy", busy, 0);
        check("rst_ovf",  ovf, 0);
        rst_n = 1'b1;
        step();

`ifndef RESP_HB_EN
        // Table-driven round-robin vectors, each applied from idle.
        for (int i = 0; i < 6; i++) begin
            $display("vector %0d req=%b", i, vecs[i].req);
            for (int k = 0; k < vecs[i].n; k++) begin
                push(vecs[i].bytes[31 - 8*k -: 8], vecs[i].acks[15 - 4*k -: 4]);
            end
            pulse_req_latency(vecs[i].req);
            serve(vecs[i].n, vecs[i].delay);
            repeat (3) step();
            check("vec_ovf", ovf, 0);
            check("vec_idle_busy", busy, 0);
        end

        // Overflow: requester 2 pulsed twice while a byte is in WAIT.
        push(8'hA5, 4'b0001);
        push(8'hC3, 4'b0100);
        pulse_req_latency(4'b0001);
        step();
        req = 4'b0100; step(); req = 4'b0000; step();
        req = 4'b0100; step(); req = 4'b0000;
        check("ovf_set", ovf, 4'b0100);
        finish_byte(3);
        serve(1, 3);
        repeat (10) step();
        check("ovf_sticky", ovf, 4'b0100);
        clr_ovf = 1'b1; step(); clr_ovf = 1'b0;
        check("ovf_clr", ovf, 0);

        // Request repeated in the cycle requester 1 is granted.
        push(8'h5A, 4'b0010);
        push(8'h5A, 4'b0010);
        req = 4'b0010; step();
        step();
        req = 4'b0000;
        check("trmt_regrant", trmt, 1);
        serve(2, 3);
        check("ovf_grant_cycle", ovf, 0);

        // Reset in WAIT with another request pending; the late tx_done is ignored.
        push(8'hA5, 4'b0001);
        pulse_req_latency(4'b0001);
        step();
        req = 4'b1000; step(); req = 4'b0000; step();
        req = 4'b1000; step(); req = 4'b0000;
        check("ovf_before_rst", ovf, 4'b1000);
        rst_n = 1'b0;
        #1;
        check("midrst_trmt", trmt, 0);
        check("midrst_resp", resp, 8'h00);
        check("midrst_ack",  ack, 0);
        check("midrst_busy", busy, 0);
        check("midrst_ovf",  ovf, 0);
        step(); step();
        rst_n   = 1'b1;
        tx_done = 1'b1;
        step();
        tx_done = 1'b0;
        check("late_done_ack", ack, 0);
        repeat (20) step();
        check("late_done_busy", busy, 0);
        check("late_done_resp", resp, 8'h00);

        // Pointer restarts at 0 after reset.
        push(8'hA5, 4'b0001);
        push(8'h5A, 4'b0010);
        pulse_req_latency(4'b0011);
        serve(2, 2);
`else
        // Heartbeat after an idle interval, no ack.
        push(8'h3C, 4'b0000);
        serve(1, 5);
        // Heartbeat arriving while requester 0 is pending waits behind it.
        push(8'hA5, 4'b0001);
        push(8'hA5, 4'b0001);
        push(8'h3C, 4'b0000);
        pulse_req_latency(4'b0001);
        step();
        req = 4'b0001; step(); req = 4'b0000;
        finish_byte(150);
        serve(2, 3);
`endif

        check("sb_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
